mips_run_ctrl: RTL and testbench
================================

Name: mips_run_ctrl

Overview:
Load-and-run sequencer for the MIPS_64 core. It streams a program image into instruction memory over a valid/ready port and initialises the core (PC, HALTED and TAKEN_BRANCH cleared). It then releases the core and watches HALTED, counting run cycles and enforcing a timeout. It sits between the test/host interface and the core, replacing direct hierarchical preloading.

Parameters:
IMEM_AW, 10, instruction memory address width (depth = 2**IMEM_AW words)
DATA_W, 64, instruction word width
CNT_W, 32, run cycle counter width
TIMEOUT_CYC, 4096, maximum run cycles before forced stop (must be >= 1)

Ports:
clk1  in  1  single controller clock (core's first-phase clock)
reset  in  1  asynchronous, active-high reset
start  in  1  begin load; honoured only in IDLE, DONE, TIMEOUT or ERR
abort  in  1  return to IDLE from any state
ld_valid  in  1  program word valid
ld_data  in  DATA_W  program word
ld_last  in  1  marks final word of the image
ld_ready  out  1  controller accepts a word this cycle
imem_we  out  1  instruction memory write enable
imem_addr  out  IMEM_AW  write address
imem_wdata  out  DATA_W  write data
core_init  out  1  one-cycle pulse: core sets PC=0, HALTED=0, TAKEN_BRANCH=0
core_hold  out  1  core stalled (no fetch/update) while high
core_halted  in  1  core HALTED flag
state  out  3  current state code
prog_len  out  IMEM_AW+1  words loaded by the last load
run_cycles  out  CNT_W  cycles spent in RUN
done  out  1  run finished by HLT
timeout  out  1  run stopped by timeout
err  out  1  image overflowed instruction memory

Behaviour:
- States and codes: IDLE=0, LOAD=1, PRIME=2, RUN=3, DONE=4, TIMEOUT=5, ERR=6.
- Reset, asynchronous: state=IDLE, core_hold=1, ld_ready=0, imem_we=0, core_init=0, imem_addr=0, prog_len=0, run_cycles=0, done/timeout/err=0.
- IDLE: core_hold=1. start -> LOAD, write pointer=0.
- Re-entering LOAD via start from DONE, TIMEOUT or ERR clears prog_len, run_cycles and all status flags.
- LOAD: ld_ready=1 and core_hold=1.
  - A transfer happens on ld_valid & ld_ready. Registered write: imem_we=1 the next cycle, with imem_addr=pointer and imem_wdata=ld_data. The pointer then increments.
  - Transfer with ld_last=1 -> PRIME, prog_len=pointer+1.
  - Transfer at pointer=2**IMEM_AW-1 with ld_last=0 -> ERR. That word is still written; ld_ready drops immediately.
  - ld_valid low: no write, no pointer change. Bubbles are allowed.
- PRIME: exactly one cycle. core_init=1, core_hold=1, ld_ready=0, the final imem write completes. -> RUN.
- RUN: core_hold=0. run_cycles increments each cycle, including the first RUN cycle.
  - core_halted=1 sampled -> DONE, done=1, core_hold=1. run_cycles keeps the value from that cycle and does not increment.
  - run_cycles reaches TIMEOUT_CYC with core_halted=0 -> TIMEOUT, timeout=1, core_hold=1.
  - core_halted and the timeout limit in the same cycle: DONE wins.
- DONE, TIMEOUT, ERR: outputs held, core_hold=1, until start or abort.
- abort: highest priority in every state. -> IDLE next cycle. Flags cleared, partially loaded imem contents untouched, in-flight write completes. abort and start together -> IDLE.
- start outside IDLE, DONE, TIMEOUT or ERR is ignored.
- run_cycles saturates at 2**CNT_W-1. It cannot reach saturation unless TIMEOUT_CYC exceeds that value.
- All outputs are registered.

Decomposition:
- Shared package mips_ctrl_pkg:
  - state codes (3-bit)
  - status bit positions
  - core_init field definitions shared with the core's PC, HALTED and TAKEN_BRANCH init logic
- One sub-module, mips_run_timer: clear/enable/saturating counter with a terminal-count compare against TIMEOUT_CYC.
- The FSM and load pointer stay in mips_run_ctrl.

Test Plan:
- Reset mid-LOAD after 3 words: assert reset asynchronously -> outputs return to reset values immediately; ld_ready=0 and core_hold=1 without waiting for clk1.
- Factorial program: 11 words (ADDI R10,R0,200 ... HLT=64'h00000000fc000000), ld_valid every cycle, last on word 10 -> imem[0..10] written in order; prog_len=11; one core_init pulse; RUN entered; when the core asserts core_halted, done=1 and run_cycles equals the count of RUN cycles. The core's DATA_MEMORY[198] then reads 5040.
- Load with ld_valid toggling 1,0,1,0 -> no duplicate or skipped addresses; imem_addr sequence is 0,1,2,...
- TIMEOUT_CYC=16, core_halted held 0 -> timeout=1 after exactly 16 RUN cycles; run_cycles=16; core_hold=1.
- IMEM_AW=2, 5-word image -> words 0..3 written, err=1 after the 4th transfer, 5th word never accepted.
- abort during RUN at cycle 5, then start -> IDLE with flags cleared; the following load begins again at address 0.

Source files
------------

// File: rtl/mips_run_ctrl_pkg.sv
// Shared definitions for the MIPS_64 load-and-run sequencer:
// state codes, status bit positions and the core init bundle.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PRIME = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4,
    S_TMO   = 3'd5,
    S_ERR   = 3'd6
  } state_e;

  localparam int ST_DONE = 0;
  localparam int ST_TMO  = 1;
  localparam int ST_ERR  = 2;
  localparam int ST_W    = 3;

  // Fields the core clears together on the init pulse.
  typedef struct packed {
    logic pc;
    logic halted;
    logic taken_branch;
  } core_init_t;

  localparam core_init_t CORE_INIT_ALL = '{
    pc: 1'b1, halted: 1'b1, taken_branch: 1'b1
  };
  localparam core_init_t CORE_INIT_NONE = '0;

  function automatic logic start_ok(state_e s);
    return s inside {S_IDLE, S_DONE, S_TMO, S_ERR};
  endfunction

endpackage

// File: rtl/mips_run_ctrl_if.sv
// Program-load, instruction-memory write and core control
// signals between the sequencer and its neighbours.
interface mips_run_ctrl_if #(
  parameter int IMEM_AW = 10,
  parameter int DATA_W  = 64
);
  logic               ld_valid;
  logic [DATA_W-1:0]  ld_data;
  logic               ld_last;
  logic               ld_ready;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [DATA_W-1:0]  imem_wdata;
  logic               core_init;
  logic               core_hold;
  logic               core_halted;

  modport master (
    input  ld_valid, ld_data, ld_last, core_halted,
    output ld_ready, imem_we, imem_addr, imem_wdata,
    output core_init, core_hold
  );

  modport slave (
    output ld_valid, ld_data, ld_last, core_halted,
    input  ld_ready, imem_we, imem_addr, imem_wdata,
    input  core_init, core_hold
  );
endinterface

// File: rtl/mips_run_ctrl_timer.sv
// Saturating run-cycle counter with a terminal-count flag
// that fires on the cycle whose increment reaches TIMEOUT_CYC.
module mips_run_timer #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);
  localparam logic [CNT_W-1:0] TC_M1 = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != '1))
      cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == TC_M1);
endmodule

// File: rtl/mips_run_ctrl.sv
// Load-and-run sequencer: streams the image into imem,
// primes the core, then runs it until HLT or timeout.
module mips_run_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int IMEM_AW     = 10,
  parameter int DATA_W      = 64,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk1,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  mips_run_ctrl_if.master    bus,
  output logic [2:0]         state,
  output logic [IMEM_AW:0]   prog_len,
  output logic [CNT_W-1:0]   run_cycles,
  output logic               done,
  output logic               timeout,
  output logic               err
);
  localparam logic [IMEM_AW-1:0] P_ONE = IMEM_AW'(1);
  localparam logic [IMEM_AW:0]   L_ONE = (IMEM_AW+1)'(1);

  state_e               state_q, state_d;
  logic [IMEM_AW-1:0]   ptr_q, ptr_d;
  logic [IMEM_AW:0]     len_q, len_d;
  logic [ST_W-1:0]      stat_q, stat_d;
  logic                 rdy_q, hold_q, we_q;
  core_init_t           init_q;
  logic [IMEM_AW-1:0]   addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic                 xfer, tmr_clr, tmr_en, tmr_tc;

  assign xfer = (state_q == S_LOAD) && bus.ld_valid && rdy_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    stat_d  = stat_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      stat_d  = '0;
    end else if (start && start_ok(state_q)) begin
      state_d = S_LOAD;
      ptr_d   = '0;
      len_d   = '0;
      stat_d  = '0;
      tmr_clr = 1'b1;
    end else begin
      unique case (state_q)
        S_LOAD: if (xfer) begin
          ptr_d = ptr_q + P_ONE;
          if (bus.ld_last) begin
            state_d = S_PRIME;
            len_d   = {1'b0, ptr_q} + L_ONE;
          end else if (&ptr_q) begin
            state_d         = S_ERR;
            stat_d[ST_ERR]  = 1'b1;
          end
        end
        S_PRIME: state_d = S_RUN;
        // Halt beats the timeout when both land together.
        S_RUN: if (bus.core_halted) begin
          state_d         = S_DONE;
          stat_d[ST_DONE] = 1'b1;
        end else begin
          tmr_en = 1'b1;
          if (tmr_tc) begin
            state_d        = S_TMO;
            stat_d[ST_TMO] = 1'b1;
          end
        end
        S_IDLE, S_DONE, S_TMO, S_ERR: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      stat_q  <= '0;
      rdy_q   <= 1'b0;
      hold_q  <= 1'b1;
      init_q  <= CORE_INIT_NONE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      stat_q  <= stat_d;
      rdy_q   <= (state_d == S_LOAD);
      hold_q  <= (state_d != S_RUN);
      init_q  <= (state_d == S_PRIME) ? CORE_INIT_ALL
                                      : CORE_INIT_NONE;
      we_q    <= xfer;
      if (xfer) begin
        addr_q  <= ptr_q;
        wdata_q <= bus.ld_data;
      end
    end
  end

  mips_run_timer #(
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk   (clk1),
    .rst   (reset),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .cnt_o (run_cycles),
    .tc_o  (tmr_tc)
  );

  assign bus.ld_ready   = rdy_q;
  assign bus.core_hold  = hold_q;
  assign bus.core_init  = |init_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign state          = state_q;
  assign prog_len       = len_q;
  assign done           = stat_q[ST_DONE];
  assign timeout        = stat_q[ST_TMO];
  assign err            = stat_q[ST_ERR];
endmodule

// File: tb/tb_mips_run_ctrl.sv
// Scenario bench for mips_run_ctrl with a small imem/core
// model: writes are logged and compared to the offered image.
module tb_mips_run_ctrl;
  localparam int AW  = 4;
  localparam int DW  = 64;
  localparam int CW  = 32;
  localparam int TMO = 16;

  logic clk1 = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [2:0]    state;
  logic [AW:0]   prog_len;
  logic [CW-1:0] run_cycles;
  logic done, timeout, err;

  mips_run_ctrl_if #(.IMEM_AW(AW), .DATA_W(DW)) bus ();

  mips_run_ctrl #(
    .IMEM_AW(AW), .DATA_W(DW), .CNT_W(CW), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk1(clk1), .reset(reset), .start(start), .abort(abort),
    .bus(bus), .state(state), .prog_len(prog_len),
    .run_cycles(run_cycles), .done(done), .timeout(timeout),
    .err(err)
  );

  always #5 clk1 = ~clk1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] img [32];
  logic [AW-1:0] wr_addr [$];
  logic [DW-1:0] wr_data [$];
  int init_cnt = 0;

  always @(negedge clk1) begin
    if (bus.imem_we === 1'b1) begin
      wr_addr.push_back(bus.imem_addr);
      wr_data.push_back(bus.imem_wdata);
    end
    if (bus.core_init === 1'b1) init_cnt <= init_cnt + 1;
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) img[i] = {$urandom, $urandom};
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: valid every cycle, 1: alternating, 2: random
  task automatic load_words(input int n, input int mode,
                            input bit mark_last, input int max_cyc,
                            output int acc);
    int cyc;
    logic v, rdy;
    acc = 0;
    cyc = 0;
    while (acc < n && cyc < max_cyc) begin
      v = (mode == 0) ? 1'b1 :
          (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      bus.ld_valid = v;
      bus.ld_data  = img[acc];
      bus.ld_last  = mark_last && (acc == n - 1);
      rdy = bus.ld_ready;
      tick();
      cyc++;
      if (v && rdy) acc++;
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #3;
    n_cmp++; if (state !== 3'd0) begin n_bad++;
      $display("FAIL rst_state: got %0d want 0", state); end
    n_cmp++; if (bus.core_hold !== 1'b1 || bus.ld_ready !== 1'b0) begin
      n_bad++; $display("FAIL rst_hold_rdy: got %b%b want 10",
                        bus.core_hold, bus.ld_ready); end
    n_cmp++; if (bus.imem_we !== 1'b0 || bus.core_init !== 1'b0 ||
                 bus.imem_addr !== '0) begin n_bad++;
      $display("FAIL rst_imem: we=%b init=%b addr=%0d want 0/0/0",
               bus.imem_we, bus.core_init, bus.imem_addr); end
    n_cmp++; if (prog_len !== '0 || run_cycles !== '0 ||
                 {done, timeout, err} !== 3'b000) begin n_bad++;
      $display("FAIL rst_status: len=%0d cyc=%0d f=%b want 0/0/000",
               prog_len, run_cycles, {done, timeout, err}); end
    tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (state !== 3'd0 || bus.core_hold !== 1'b1) begin
      n_bad++; $display("FAIL idle_after_rst: st=%0d hold=%b want 0/1",
                        state, bus.core_hold); end
  endtask

  task automatic test_factorial();
    int acc, h, w, i0;
    fill(11);
    img[10] = 64'h00000000fc000000;
    i0 = init_cnt;
    do_start();
    load_words(11, 0, 1'b1, 40, acc);
    n_cmp++; if (acc != 11 || state !== 3'd2 || bus.ld_ready !== 1'b0)
      begin n_bad++; $display("FAIL fact_prime: acc=%0d st=%0d rdy=%b want 11/2/0",
                              acc, state, bus.ld_ready); end
    w = 0;
    while (bus.core_hold && w < 8) begin tick(); w++; end
    n_cmp++; if (bus.core_hold !== 1'b0 || state !== 3'd3) begin
      n_bad++; $display("FAIL fact_run_entry: hold=%b st=%0d want 0/3",
                        bus.core_hold, state); end
    h = $urandom_range(1, 14);
    repeat (h) tick();
    bus.core_halted = 1'b1;
    tick();
    bus.core_halted = 1'b0;
    n_cmp++; if (state !== 3'd4 || done !== 1'b1 || timeout !== 1'b0 ||
                 bus.core_hold !== 1'b1) begin n_bad++;
      $display("FAIL fact_done: st=%0d d=%b t=%b hold=%b want 4/1/0/1",
               state, done, timeout, bus.core_hold); end
    n_cmp++; if (run_cycles !== CW'(h)) begin n_bad++;
      $display("FAIL fact_cycles: got %0d want %0d", run_cycles, h); end
    repeat (3) tick();
    n_cmp++; if (run_cycles !== CW'(h) || done !== 1'b1 ||
                 prog_len !== 5'd11) begin n_bad++;
      $display("FAIL fact_hold: cyc=%0d d=%b len=%0d want %0d/1/11",
               run_cycles, done, prog_len, h); end
    n_cmp++; if (init_cnt - i0 != 1) begin n_bad++;
      $display("FAIL fact_init_pulses: got %0d want 1", init_cnt - i0); end
    n_cmp++; if (wr_addr.size() != 11) begin n_bad++;
      $display("FAIL fact_nwrites: got %0d want 11", wr_addr.size()); end
    for (int i = 0; i < wr_addr.size() && i < 11; i++) begin
      n_cmp++; if (wr_addr[i] !== AW'(i) || wr_data[i] !== img[i]) begin
        n_bad++; $display("FAIL fact_write[%0d]: addr=%0d data=%h want %0d/%h",
                          i, wr_addr[i], wr_data[i], i, img[i]); end
    end
  endtask

  task automatic test_bubbles_timeout();
    int acc, w, cnt;
    fill(6);
    do_start();
    n_cmp++; if (state !== 3'd1 || done !== 1'b0 || prog_len !== '0 ||
                 run_cycles !== '0) begin n_bad++;
      $display("FAIL restart_clear: st=%0d d=%b len=%0d cyc=%0d want 1/0/0/0",
               state, done, prog_len, run_cycles); end
    load_words(6, 1, 1'b1, 40, acc);
    w = 0;
    while (bus.core_hold && w < 8) begin tick(); w++; end
    n_cmp++; if (wr_addr.size() != 6) begin n_bad++;
      $display("FAIL bub_nwrites: got %0d want 6", wr_addr.size()); end
    for (int i = 0; i < wr_addr.size() && i < 6; i++) begin
      n_cmp++; if (wr_addr[i] !== AW'(i) || wr_data[i] !== img[i]) begin
        n_bad++; $display("FAIL bub_write[%0d]: addr=%0d data=%h want %0d/%h",
                          i, wr_addr[i], wr_data[i], i, img[i]); end
    end
    cnt = 0;
    while (!bus.core_hold && cnt < 40) begin
      start = (cnt == 3);
      tick();
      cnt++;
    end
    start = 1'b0;
    n_cmp++; if (cnt != TMO) begin n_bad++;
      $display("FAIL tmo_run_len: got %0d want %0d", cnt, TMO); end
    n_cmp++; if (state !== 3'd5 || timeout !== 1'b1 || done !== 1'b0 ||
                 bus.core_hold !== 1'b1) begin n_bad++;
      $display("FAIL tmo_state: st=%0d t=%b d=%b hold=%b want 5/1/0/1",
               state, timeout, done, bus.core_hold); end
    n_cmp++; if (run_cycles !== CW'(TMO) || prog_len !== 5'd6) begin
      n_bad++; $display("FAIL tmo_counts: cyc=%0d len=%0d want %0d/6",
                        run_cycles, prog_len, TMO); end
  endtask

  task automatic test_overflow();
    int acc;
    fill(17);
    do_start();
    load_words(17, 2, 1'b1, 80, acc);
    n_cmp++; if (acc != 16) begin n_bad++;
      $display("FAIL ovf_accepted: got %0d want 16", acc); end
    n_cmp++; if (state !== 3'd6 || err !== 1'b1 || bus.ld_ready !== 1'b0 ||
                 timeout !== 1'b0) begin n_bad++;
      $display("FAIL ovf_state: st=%0d e=%b rdy=%b t=%b want 6/1/0/0",
               state, err, bus.ld_ready, timeout); end
    n_cmp++; if (wr_addr.size() != 16 || prog_len !== '0) begin n_bad++;
      $display("FAIL ovf_nwrites: got %0d len=%0d want 16/0",
               wr_addr.size(), prog_len); end
    for (int i = 0; i < wr_addr.size() && i < 16; i++) begin
      n_cmp++; if (wr_addr[i] !== AW'(i) || wr_data[i] !== img[i]) begin
        n_bad++; $display("FAIL ovf_write[%0d]: addr=%0d data=%h want %0d/%h",
                          i, wr_addr[i], wr_data[i], i, img[i]); end
    end
  endtask

  task automatic test_abort();
    int acc, w;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++; if (state !== 3'd0 || err !== 1'b0 || bus.core_hold !== 1'b1)
      begin n_bad++; $display("FAIL abort_err: st=%0d e=%b hold=%b want 0/0/1",
                              state, err, bus.core_hold); end
    fill(4);
    do_start();
    load_words(4, 0, 1'b1, 20, acc);
    w = 0;
    while (bus.core_hold && w < 8) begin tick(); w++; end
    repeat (4) tick();
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    n_cmp++; if (state !== 3'd0 || bus.core_hold !== 1'b1 ||
                 {done, timeout, err} !== 3'b000) begin n_bad++;
      $display("FAIL abort_run: st=%0d hold=%b f=%b want 0/1/000",
               state, bus.core_hold, {done, timeout, err}); end
    tick();
    n_cmp++; if (state !== 3'd0) begin n_bad++;
      $display("FAIL abort_start_idle: got %0d want 0", state); end
    fill(3);
    do_start();
    load_words(3, 2, 1'b1, 40, acc);
    repeat (2) tick();
    n_cmp++; if (wr_addr.size() != 3 || prog_len !== 5'd3) begin n_bad++;
      $display("FAIL reload_n: got %0d len=%0d want 3/3",
               wr_addr.size(), prog_len); end
    for (int i = 0; i < wr_addr.size() && i < 3; i++) begin
      n_cmp++; if (wr_addr[i] !== AW'(i) || wr_data[i] !== img[i]) begin
        n_bad++; $display("FAIL reload_write[%0d]: addr=%0d data=%h want %0d/%h",
                          i, wr_addr[i], wr_data[i], i, img[i]); end
    end
  endtask

  task automatic test_reset_mid_load();
    int acc, w;
    w = 0;
    while (state == 3'd3 && w < 40) begin tick(); w++; end
    fill(5);
    do_start();
    load_words(3, 0, 1'b0, 20, acc);
    n_cmp++; if (state !== 3'd1 || bus.imem_we !== 1'b1 ||
                 bus.imem_addr !== AW'(2)) begin n_bad++;
      $display("FAIL mid_load: st=%0d we=%b addr=%0d want 1/1/2",
               state, bus.imem_we, bus.imem_addr); end
    #3 reset = 1'b1;
    #1;
    n_cmp++; if (state !== 3'd0 || bus.ld_ready !== 1'b0 ||
                 bus.core_hold !== 1'b1) begin n_bad++;
      $display("FAIL async_rst: st=%0d rdy=%b hold=%b want 0/0/1",
               state, bus.ld_ready, bus.core_hold); end
    n_cmp++; if (bus.imem_we !== 1'b0 || bus.imem_addr !== '0 ||
                 prog_len !== '0 || run_cycles !== '0) begin n_bad++;
      $display("FAIL async_rst_out: we=%b addr=%0d len=%0d cyc=%0d want 0",
               bus.imem_we, bus.imem_addr, prog_len, run_cycles); end
    #1 reset = 1'b0;
    tick();
    n_cmp++; if (state !== 3'd0 || bus.ld_ready !== 1'b0) begin n_bad++;
      $display("FAIL post_rst: st=%0d rdy=%b want 0/0", state, bus.ld_ready); end
  endtask

  initial begin
    bus.ld_valid    = 1'b0;
    bus.ld_data     = '0;
    bus.ld_last     = 1'b0;
    bus.core_halted = 1'b0;
    test_reset();
    test_factorial();
    test_bubbles_timeout();
    test_overflow();
    test_abort();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
